apb_rr_arbiter: RTL and testbench
=================================

// Module: apb_rr_arbiter
// PURPOSE
//   N-master to 1-slave APB interconnect with round-robin arbitration and a slave-response timeout.
//   Replaces OR-merging of master buses in front of the shared Memory slave.
//   Only the granted master's signals reach the slave. Other requesters are held off by
//   m_pready_o=0 until they win. Generates clean SETUP/ACCESS phases toward the slave.
// PARAMETERS
//   N_MASTERS      2   number of APB masters (>=2)
//   ADDR_W         8   paddr width
//   DATA_W         32  pwdata/prdata width
//   TIMEOUT_CYCLES 16  max ACCESS cycles waiting for s_pready_i; 0 disables timeout
// PORTS
//   pclk_i       in   1               clock, rising edge
//   presetn_i    in   1               reset, asynchronous, active-low
//   m_psel_i     in   N_MASTERS       per-master psel
//   m_penable_i  in   N_MASTERS       per-master penable (ignored for timing; slave phase generated here)
//   m_pwrite_i   in   N_MASTERS       per-master pwrite
//   m_paddr_i    in   N_MASTERS*ADDR_W  master i at [i*ADDR_W +: ADDR_W]
//   m_pwdata_i   in   N_MASTERS*DATA_W  master i at [i*DATA_W +: DATA_W]
//   m_prdata_o   out  DATA_W          read data, broadcast to all masters
//   m_pready_o   out  N_MASTERS       pready, one-hot to granted master only
//   m_pslverr_o  out  N_MASTERS       pslverr, qualified by m_pready_o
//   s_psel_o     out  1               slave psel
//   s_penable_o  out  1               slave penable
//   s_pwrite_o   out  1               slave pwrite (granted master)
//   s_paddr_o    out  ADDR_W          slave paddr (granted master)
//   s_pwdata_o   out  DATA_W          slave pwdata (granted master)
//   s_prdata_i   in   DATA_W          slave read data
//   s_pready_i   in   1               slave ready
//   s_pslverr_i  in   1               slave error
//   grant_o      out  N_MASTERS       one-hot current grant, 0 when IDLE
//   timeout_o    out  1               1-cycle pulse when a transfer is aborted by timeout
// BEHAVIOUR
//   Reset: state=IDLE, grant=0, last_grant=N_MASTERS-1 (master 0 wins first), timeout counter=0.
//     All outputs are 0 while presetn_i=0. Reset mid-transfer aborts it; no pready is returned.
//   FSM IDLE: if |m_psel_i, latch winner into grant -> SETUP. Otherwise stay.
//     Winner: first set psel scanning last_grant+1, +2, ... modulo N_MASTERS.
//   FSM SETUP: s_psel_o=1, s_penable_o=0 -> ACCESS unconditionally (1 cycle).
//   FSM ACCESS: s_psel_o=1, s_penable_o=1, counter++.
//     If s_pready_i: m_pready_o[grant]=1 and m_pslverr_o[grant]=s_pslverr_i (same cycle, combinational);
//       last_grant<=grant -> IDLE.
//     Else if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: m_pready_o[grant]=1, m_pslverr_o[grant]=1,
//       timeout_o=1, last_grant<=grant -> IDLE. Slave psel drops next cycle.
//   s_paddr_o/s_pwrite_o/s_pwdata_o: combinational mux from the granted master in SETUP/ACCESS, 0 in IDLE.
//   Masters must hold address, data and write stable while their psel=1 and pready=0 (APB rule).
//   m_prdata_o = s_prdata_i at all times. Only meaningful in the pready cycle.
//   Latency: psel seen in IDLE at cycle 0 -> SETUP at 1 -> ACCESS at 2. With a zero-wait slave,
//     pready is returned at cycle 2. Minimum 3 cycles per transfer (IDLE gap between transfers).
//   Grant is locked from SETUP until return to IDLE. psel changes on other masters are ignored meanwhile.
//   A granted master dropping psel mid-transfer: transfer still completes to the slave; pready is still pulsed.
//   A master with psel=1 and penable=1 that is not granted keeps waiting. No starvation:
//     a waiting master is served within N_MASTERS-1 other transfers.
// TESTING
//   Single master 0 writes addr 0x10 data 0xDEADBEEF, zero-wait slave -> s_psel 1 at cyc1, s_penable 1 at cyc2, m_pready_o=01 at cyc2.
//   Masters 0 and 1 both request from reset -> grant order 0,1,0,1 across 4 back-to-back transfers; each write lands at the correct slave address.
//   N_MASTERS=3, all request continuously -> grant sequence 0,1,2,0; no master waits more than 2 transfers.
//   Slave holds pready=0, TIMEOUT_CYCLES=4 -> 4th ACCESS cycle gives m_pready+m_pslverr to granted master and timeout_o pulse; next master is granted.
//   Slave returns pslverr=1 on a read of 0xFF -> only granted master sees pslverr, prdata broadcast; other masters see pready=0.
//   presetn_i low during ACCESS -> all outputs 0 asynchronously; after release, master 0 has priority.

Source files
------------

// File: rtl/apb_rr_arbiter_if.sv
// APB bundle between N requesting masters, the round-robin arbiter and the shared slave.
// The master modport is the requesting side; the slave modport is the arbiter's view.
interface apb_rr_arbiter_if #(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 32
);
  logic [N_MASTERS-1:0]        m_psel_i;
  logic [N_MASTERS-1:0]        m_penable_i;
  logic [N_MASTERS-1:0]        m_pwrite_i;
  logic [N_MASTERS*ADDR_W-1:0] m_paddr_i;
  logic [N_MASTERS*DATA_W-1:0] m_pwdata_i;
  logic [DATA_W-1:0]           m_prdata_o;
  logic [N_MASTERS-1:0]        m_pready_o;
  logic [N_MASTERS-1:0]        m_pslverr_o;
  logic                        s_psel_o;
  logic                        s_penable_o;
  logic                        s_pwrite_o;
  logic [ADDR_W-1:0]           s_paddr_o;
  logic [DATA_W-1:0]           s_pwdata_o;
  logic [DATA_W-1:0]           s_prdata_i;
  logic                        s_pready_i;
  logic                        s_pslverr_i;
  logic [N_MASTERS-1:0]        grant_o;
  logic                        timeout_o;

  modport slave (
    input  m_psel_i, m_penable_i, m_pwrite_i, m_paddr_i, m_pwdata_i,
    input  s_prdata_i, s_pready_i, s_pslverr_i,
    output m_prdata_o, m_pready_o, m_pslverr_o,
    output s_psel_o, s_penable_o, s_pwrite_o, s_paddr_o, s_pwdata_o,
    output grant_o, timeout_o
  );

  modport master (
    output m_psel_i, m_penable_i, m_pwrite_i, m_paddr_i, m_pwdata_i,
    output s_prdata_i, s_pready_i, s_pslverr_i,
    input  m_prdata_o, m_pready_o, m_pslverr_o,
    input  s_psel_o, s_penable_o, s_pwrite_o, s_paddr_o, s_pwdata_o,
    input  grant_o, timeout_o
  );
endinterface

// File: rtl/apb_rr_arbiter.sv
// N-master to 1-slave APB interconnect: round-robin grant, locally generated SETUP/ACCESS
// phases toward the slave, and an optional ACCESS-phase timeout that errors the transfer.
module apb_rr_arbiter #(
  parameter int unsigned N_MASTERS      = 2,
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic             pclk_i,
  input logic             presetn_i,
  apb_rr_arbiter_if.slave bus
);
  localparam int unsigned IDX_W   = $clog2(N_MASTERS);
  localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e               state_q, state_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]     gidx_q, gidx_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     cand;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_found;
  logic                 timeout_hit;
  logic                 done;
  logic                 unused_penable;

  // Master penable carries no timing information here; slave phases are generated locally.
  assign unused_penable = ^bus.m_penable_i;

  assign timeout_hit = (state_q == StAccess) && !bus.s_pready_i && (TIMEOUT_CYCLES != 0) &&
                       (cnt_q == CNT_W'(TO_LAST));
  assign done        = (state_q == StAccess) && (bus.s_pready_i || timeout_hit);

  // Scan from the master after the last one served, wrapping around.
  always_comb begin
    cand      = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int i = 1; i <= int'(N_MASTERS); i++) begin
      cand = IDX_W'((int'(last_q) + i) % int'(N_MASTERS));
      if (!win_found && bus.m_psel_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      state_q <= StIdle;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IDX_W'(N_MASTERS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (win_found) begin
          grant_d = {{(N_MASTERS-1){1'b0}}, 1'b1} << win_idx;
          gidx_d  = win_idx;
          state_d = StSetup;
        end
      end
      StSetup: state_d = StAccess;
      StAccess: begin
        cnt_d = cnt_q + 1'b1;
        if (done) begin
          state_d = StIdle;
          grant_d = '0;
          last_d  = gidx_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.s_psel_o    = 1'b0;
    bus.s_penable_o = 1'b0;
    bus.s_pwrite_o  = 1'b0;
    bus.s_paddr_o   = '0;
    bus.s_pwdata_o  = '0;
    bus.m_pready_o  = '0;
    bus.m_pslverr_o = '0;
    bus.timeout_o   = 1'b0;
    bus.grant_o     = grant_q;
    // Gated so that every output reads zero while reset is held.
    bus.m_prdata_o  = presetn_i ? bus.s_prdata_i : '0;
    if (state_q != StIdle) begin
      bus.s_psel_o    = 1'b1;
      bus.s_penable_o = (state_q == StAccess);
      bus.s_pwrite_o  = bus.m_pwrite_i[gidx_q];
      bus.s_paddr_o   = bus.m_paddr_i[int'(gidx_q) * ADDR_W +: ADDR_W];
      bus.s_pwdata_o  = bus.m_pwdata_i[int'(gidx_q) * DATA_W +: DATA_W];
    end
    if (done) begin
      bus.m_pready_o  = grant_q;
      bus.m_pslverr_o = (bus.s_pslverr_i || timeout_hit) ? grant_q : '0;
      bus.timeout_o   = timeout_hit;
    end
  end
endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed bench: a cycle table for a 2-master/timeout-4 instance, plus hand-written
// sequences for async reset and a 3-master instance with the timeout disabled.
module tb_apb_rr_arbiter;
  logic clk;
  logic rstn;
  int   n_pass;
  int   n_total;

  apb_rr_arbiter_if #(.N_MASTERS(2), .ADDR_W(8), .DATA_W(32)) b2 ();
  apb_rr_arbiter_if #(.N_MASTERS(3), .ADDR_W(8), .DATA_W(32)) b3 ();

  apb_rr_arbiter #(.N_MASTERS(2), .ADDR_W(8), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut2 (
    .pclk_i    (clk),
    .presetn_i (rstn),
    .bus       (b2)
  );

  apb_rr_arbiter #(.N_MASTERS(3), .ADDR_W(8), .DATA_W(32), .TIMEOUT_CYCLES(0)) dut3 (
    .pclk_i    (clk),
    .presetn_i (rstn),
    .bus       (b3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] psel;
    logic       pready;
    logic       pslverr;
    logic [1:0] grant;
    logic       spsel;
    logic       spen;
    logic [1:0] mready;
    logic [1:0] merr;
    logic       tout;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [1:0] psel, input logic pready, input logic pslverr,
                     input logic [1:0] grant, input logic spsel, input logic spen,
                     input logic [1:0] mready, input logic [1:0] merr, input logic tout);
    vec_t v;
    v = '{psel, pready, pslverr, grant, spsel, spen, mready, merr, tout};
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h, expected %h", name, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Master 0: write 0xDEADBEEF to 0x10. Master 1: read of 0xFF.
  function automatic logic [81:0] exp_of(input vec_t v);
    logic [7:0]  a;
    logic [31:0] d;
    logic        w;
    case (v.grant)
      2'b01:   begin a = 8'h10; d = 32'hDEADBEEF; w = 1'b1; end
      2'b10:   begin a = 8'hFF; d = 32'h12345678; w = 1'b0; end
      default: begin a = 8'h00; d = 32'h0;        w = 1'b0; end
    endcase
    return {v.grant, v.spsel, v.spen, v.mready, v.merr, v.tout, a, d, w, 32'hCAFEF00D};
  endfunction

  function automatic logic [81:0] got2();
    return {b2.grant_o, b2.s_psel_o, b2.s_penable_o, b2.m_pready_o, b2.m_pslverr_o,
            b2.timeout_o, b2.s_paddr_o, b2.s_pwdata_o, b2.s_pwrite_o, b2.m_prdata_o};
  endfunction

  initial begin
    logic [2:0] exp3 [4];
    logic       leak;
    n_pass  = 0;
    n_total = 0;
    rstn    = 1'b0;

    b2.m_psel_i    = '0;
    b2.m_penable_i = '0;
    b2.m_pwrite_i  = 2'b01;
    b2.m_paddr_i   = {8'hFF, 8'h10};
    b2.m_pwdata_i  = {32'h12345678, 32'hDEADBEEF};
    b2.s_prdata_i  = 32'hCAFEF00D;
    b2.s_pready_i  = 1'b0;
    b2.s_pslverr_i = 1'b0;
    b3.m_psel_i    = '0;
    b3.m_penable_i = '0;
    b3.m_pwrite_i  = 3'b111;
    b3.m_paddr_i   = {8'h30, 8'h20, 8'h10};
    b3.m_pwdata_i  = {32'h3, 32'h2, 32'h1};
    b3.s_prdata_i  = 32'h0;
    b3.s_pready_i  = 1'b0;
    b3.s_pslverr_i = 1'b0;

    //   psel   rdy   err   grant  spsel spen  mrdy   merr   tout
    add(2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);  // idle, both request
    add(2'b11, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);  // master 0 first
    add(2'b11, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 2'b01, 2'b00, 1'b0);
    add(2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    add(2'b11, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
    add(2'b11, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 2'b10, 2'b00, 1'b0);
    add(2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    add(2'b11, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
    add(2'b11, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 2'b01, 2'b00, 1'b0);
    add(2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    add(2'b11, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
    add(2'b11, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 2'b10, 2'b00, 1'b0);
    add(2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);  // nobody requests
    add(2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    add(2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
    add(2'b00, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0);  // granted drops psel
    add(2'b10, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0);  // err w/o ready hidden
    add(2'b11, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0);
    add(2'b11, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 2'b01, 2'b01, 1'b1);  // 4th ACCESS: timeout
    add(2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    add(2'b11, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
    add(2'b11, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 2'b10, 2'b10, 1'b0);  // slave error on 0xFF
    add(2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);

    @(negedge clk);
    check("reset_outputs_zero", 128'(got2()), 128'(0));
    rstn = 1'b1;
    tick();

    foreach (vq[i]) begin
      b2.m_psel_i    = vq[i].psel;
      b2.m_penable_i = vq[i].psel;
      b2.s_pready_i  = vq[i].pready;
      b2.s_pslverr_i = vq[i].pslverr;
      @(negedge clk);
      check($sformatf("row%0d", i), 128'(got2()), 128'(exp_of(vq[i])));
      tick();
    end

    // Master 0 completes (last grant = 0), then master 1 is caught mid-ACCESS by reset.
    b2.m_psel_i   = 2'b01;
    b2.s_pready_i = 1'b1;
    tick();
    tick();
    tick();
    b2.m_psel_i   = 2'b11;
    b2.s_pready_i = 1'b0;
    tick();
    tick();
    check("pre_reset_grant", 128'({b2.grant_o, b2.s_penable_o}), 128'({2'b10, 1'b1}));
    #2;
    rstn = 1'b0;
    #1;
    check("async_reset_zero", 128'(got2()), 128'(0));
    @(negedge clk);
    check("reset_hold_zero", 128'(got2()), 128'(0));
    rstn = 1'b1;
    b2.s_pready_i = 1'b1;
    tick();
    check("post_reset_priority", 128'({b2.grant_o, b2.s_psel_o}), 128'({2'b01, 1'b1}));
    b2.m_psel_i = 2'b00;

    // Three masters requesting continuously rotate 0,1,2,0.
    exp3[0] = 3'b001;
    exp3[1] = 3'b010;
    exp3[2] = 3'b100;
    exp3[3] = 3'b001;
    b3.m_psel_i   = 3'b111;
    b3.s_pready_i = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tick();
      check($sformatf("rr3_grant%0d", t), 128'(b3.grant_o), 128'(exp3[t]));
      tick();
      check($sformatf("rr3_pready%0d", t), 128'(b3.m_pready_o), 128'(exp3[t]));
      tick();
    end

    // Timeout disabled: a stalled slave holds the transfer indefinitely.
    b3.m_psel_i   = 3'b001;
    b3.s_pready_i = 1'b0;
    tick();
    leak = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (b3.m_pready_o != 3'b000 || b3.timeout_o) leak = 1'b1;
    end
    check("no_timeout_when_disabled", 128'({leak, b3.s_penable_o}), 128'({1'b0, 1'b1}));
    b3.s_pready_i = 1'b1;
    #1;
    check("stalled_then_ready", 128'(b3.m_pready_o), 128'(3'b001));
    tick();
    b3.m_psel_i = 3'b000;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
